// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register built as a two-entry skid buffer. in_ready is a flop,
// so nothing combinational runs from out_ready back to in_ready.
module id_ex_pipe #(
  parameter int          XLEN       = 64,
  parameter int          RW         = 5,
  parameter int          FW         = 4,
  parameter int          AW         = 2,
  // Value loaded into stall_cnt at reset; 0 in a real pipeline.
  parameter logic [31:0] STALL_INIT = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RW-1:0]   in_rs1,
  input  logic [RW-1:0]   in_rs2,
  input  logic [RW-1:0]   in_rd,
  input  logic [FW-1:0]   in_funct,
  input  logic [AW-1:0]   in_aluop,
  input  logic [5:0]      in_ctrl,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [RW-1:0]   out_rs1,
  output logic [RW-1:0]   out_rs2,
  output logic [RW-1:0]   out_rd,
  output logic [FW-1:0]   out_funct,
  output logic [AW-1:0]   out_aluop,
  output logic [5:0]      out_ctrl,

  output logic [31:0]     stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [FW-1:0]   funct;
    logic [AW-1:0]   aluop;
    logic [5:0]      ctrl;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  entry_t      main_q, main_d;
  entry_t      skid_q, skid_d;
  entry_t      in_entry;
  logic        in_ready_q, in_ready_d;
  logic [31:0] stall_q, stall_d;
  logic        in_fire;
  logic        out_fire;
  logic        stalled;

  assign in_entry = '{
    pc:       in_pc,
    rs1_data: in_rs1_data,
    rs2_data: in_rs2_data,
    imm:      in_imm,
    rs1:      in_rs1,
    rs2:      in_rs2,
    rd:       in_rd,
    funct:    in_funct,
    aluop:    in_aluop,
    ctrl:     in_ctrl
  };

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;
  assign stalled   = out_valid & ~out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_entry;
            state_d = FULL;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            skid_d  = in_entry;
            state_d = SKID;
          end else if (out_fire) begin
            // Clearing main keeps out_ctrl at zero while the stage is a bubble.
            main_d  = '0;
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  assign in_ready_d = (state_d != SKID);
  assign stall_d    = (stalled && (stall_q != 32'hFFFF_FFFF)) ? stall_q + 32'd1 : stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      stall_q    <= STALL_INIT;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  assign out_pc       = main_q.pc;
  assign out_rs1_data = main_q.rs1_data;
  assign out_rs2_data = main_q.rs2_data;
  assign out_imm      = main_q.imm;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_rd       = main_q.rd;
  assign out_funct    = main_q.funct;
  assign out_aluop    = main_q.aluop;
  assign out_ctrl     = main_q.ctrl;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: a 64-bit and a 32-bit instance share one stimulus stream
// and are checked against a queue scoreboard every cycle.
module tb_id_ex_pipe;

  localparam logic [31:0] INIT32 = 32'hFFFF_FFF0;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] rs1d;
    logic [63:0] rs2d;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  funct;
    logic [1:0]  aluop;
    logic [5:0]  ctrl;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [63:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [3:0]  in_funct;
  logic [1:0]  in_aluop;
  logic [5:0]  in_ctrl;

  logic        in_ready, out_valid;
  logic [63:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_funct;
  logic [1:0]  out_aluop;
  logic [5:0]  out_ctrl;
  logic [31:0] stall_cnt;

  logic        in_ready32, out_valid32;
  logic [31:0] out_pc32, out_rs1_data32, out_rs2_data32, out_imm32;
  logic [4:0]  out_rs1_32, out_rs2_32, out_rd32;
  logic [3:0]  out_funct32;
  logic [1:0]  out_aluop32;
  logic [5:0]  out_ctrl32;
  logic [31:0] stall_cnt32;

  always #5 clk = ~clk;

  id_ex_pipe #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_funct(in_funct), .in_aluop(in_aluop), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct(out_funct), .out_aluop(out_aluop), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  id_ex_pipe #(.XLEN(32), .STALL_INIT(INIT32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_pc(in_pc[31:0]), .in_rs1_data(in_rs1_data[31:0]), .in_rs2_data(in_rs2_data[31:0]),
    .in_imm(in_imm[31:0]),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_funct(in_funct), .in_aluop(in_aluop), .in_ctrl(in_ctrl),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_pc(out_pc32), .out_rs1_data(out_rs1_data32), .out_rs2_data(out_rs2_data32),
    .out_imm(out_imm32),
    .out_rs1(out_rs1_32), .out_rs2(out_rs2_32), .out_rd(out_rd32),
    .out_funct(out_funct32), .out_aluop(out_aluop32), .out_ctrl(out_ctrl32),
    .stall_cnt(stall_cnt32)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  ent_t        sb[$];
  bit          exp_rdy;
  logic [31:0] m_cnt, m_cnt32;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic ent_t rand_ent(input logic [63:0] pc);
    ent_t e;
    e.pc    = pc;
    e.rs1d  = {$urandom, $urandom};
    e.rs2d  = {$urandom, $urandom};
    e.imm   = {$urandom, $urandom};
    e.rs1   = 5'($urandom);
    e.rs2   = 5'($urandom);
    e.rd    = 5'($urandom);
    e.funct = 4'($urandom);
    e.aluop = 2'($urandom);
    e.ctrl  = 6'($urandom);
    return e;
  endfunction

  // One clock: check outputs against the scoreboard, drive inputs, update the model.
  task automatic cycle(input bit v, input bit rdy, input bit fl, input ent_t e);
    ent_t f;
    bit   held;
    held = (sb.size() != 0);
    check_eq("out_valid", 64'(out_valid), 64'(held));
    check_eq("out_valid32", 64'(out_valid32), 64'(held));
    check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    check_eq("in_ready32", 64'(in_ready32), 64'(exp_rdy));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    check_eq("stall_cnt32", 64'(stall_cnt32), 64'(m_cnt32));
    if (!held) begin
      check_eq("bubble_ctrl", 64'(out_ctrl), 64'd0);
      check_eq("bubble_ctrl32", 64'(out_ctrl32), 64'd0);
    end else begin
      f = sb[0];
      check_eq("out_pc", out_pc, f.pc);
      check_eq("out_rs1_data", out_rs1_data, f.rs1d);
      check_eq("out_rs2_data", out_rs2_data, f.rs2d);
      check_eq("out_imm", out_imm, f.imm);
      check_eq("out_fields", 64'({out_rs1, out_rs2, out_rd, out_funct, out_aluop, out_ctrl}),
               64'({f.rs1, f.rs2, f.rd, f.funct, f.aluop, f.ctrl}));
      check_eq("out_data32", {out_pc32, out_imm32}, {f.pc[31:0], f.imm[31:0]});
      check_eq("out_regs32", {out_rs1_data32, out_rs2_data32}, {f.rs1d[31:0], f.rs2d[31:0]});
      check_eq("out_fields32",
               64'({out_rs1_32, out_rs2_32, out_rd32, out_funct32, out_aluop32, out_ctrl32}),
               64'({f.rs1, f.rs2, f.rd, f.funct, f.aluop, f.ctrl}));
    end
    in_valid = v; out_ready = rdy; flush = fl;
    in_pc = e.pc; in_rs1_data = e.rs1d; in_rs2_data = e.rs2d; in_imm = e.imm;
    in_rs1 = e.rs1; in_rs2 = e.rs2; in_rd = e.rd;
    in_funct = e.funct; in_aluop = e.aluop; in_ctrl = e.ctrl;
    if (held && !rdy) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_cnt32 != 32'hFFFF_FFFF) m_cnt32 = m_cnt32 + 1;
    end
    if (held && rdy) begin
      f = sb.pop_front();
      if (v || fl) $display("xfer out pc=0x%0h", f.pc);
    end
    if (fl) sb.delete();
    else if (v && exp_rdy) sb.push_back(e);
    exp_rdy = (sb.size() < 2);
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rdy, 1'b0, rand_ent(64'hDEAD));
  endtask

  task automatic do_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_ctrl = 6'b111111;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_eq("rst_valid", 64'({out_valid, out_valid32}), 64'd0);
      check_eq("rst_in_ready", 64'({in_ready, in_ready32}), 64'd0);
      check_eq("rst_pc", out_pc, 64'd0);
      check_eq("rst_data", out_rs1_data | out_rs2_data | out_imm, 64'd0);
      check_eq("rst_fields", 64'({out_rs1, out_rs2, out_rd, out_funct, out_aluop, out_ctrl}), 64'd0);
      check_eq("rst_out32", {out_pc32, out_imm32 | out_rs1_data32 | out_rs2_data32}, 64'd0);
      check_eq("rst_ctrl32", 64'(out_ctrl32), 64'd0);
      check_eq("rst_stall", 64'(stall_cnt), 64'd0);
      check_eq("rst_stall32", 64'(stall_cnt32), 64'(INIT32));
    end
    reset = 1'b1; in_valid = 1'b0;
    sb.delete(); exp_rdy = 1'b0; m_cnt = 32'd0; m_cnt32 = INIT32;
  endtask

  initial begin
    ent_t e;
    int   budget;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_funct = '0; in_aluop = '0; in_ctrl = '0;
    @(posedge clk); #1;
    do_reset();

    // Back-to-back stream, one entry per cycle.
    idle(1'b1, 1);
    check_eq("ready_after_reset", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, rand_ent(64'(i * 4)));
    idle(1'b1, 2);

    // A held, B goes to skid, then both drain in order.
    cycle(1'b1, 1'b0, 1'b0, rand_ent(64'h100));
    cycle(1'b1, 1'b0, 1'b0, rand_ent(64'h104));
    check_eq("skid_in_ready", 64'(in_ready), 64'd0);
    check_eq("skid_head_pc", out_pc, 64'h100);
    idle(1'b0, 3);
    idle(1'b1, 3);

    // Flush while in SKID with a live input, then while FULL with a completing output.
    cycle(1'b1, 1'b0, 1'b0, rand_ent(64'h180));
    cycle(1'b1, 1'b0, 1'b0, rand_ent(64'h184));
    cycle(1'b1, 1'b0, 1'b1, rand_ent(64'h200));
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    check_eq("flush_ctrl", 64'(out_ctrl), 64'd0);
    idle(1'b1, 2);
    cycle(1'b1, 1'b0, 1'b0, rand_ent(64'h280));
    cycle(1'b1, 1'b1, 1'b1, rand_ent(64'h300));
    idle(1'b1, 2);

    // Reset while FULL with every control bit set.
    e = rand_ent(64'h400);
    e.ctrl = 6'b111111;
    cycle(1'b1, 1'b0, 1'b0, e);
    idle(1'b0, 1);
    do_reset();
    idle(1'b1, 1);

    // Saturation of the 32-bit instance, whose counter starts near the top.
    cycle(1'b1, 1'b0, 1'b0, rand_ent(64'h500));
    idle(1'b0, 14);
    check_eq("sat_pre", 64'(stall_cnt32), 64'hFFFF_FFFE);
    idle(1'b0, 3);
    check_eq("sat_top", 64'(stall_cnt32), 64'hFFFF_FFFF);
    idle(1'b0, 2);
    check_eq("sat_hold", 64'(stall_cnt32), 64'hFFFF_FFFF);
    check_eq("stall_nosat", 64'(stall_cnt), 64'd19);
    idle(1'b1, 2);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 4, rand_ent({$urandom, $urandom}));
    end
    budget = 0;
    while (sb.size() != 0 && budget < 10) begin
      idle(1'b1, 1);
      budget++;
    end
    check_eq("drain_done", 64'(sb.size()), 64'd0);
    idle(1'b1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter XLEN, 64, width of PC, register-data and immediate fields.
REQ-002 Parameter RW, 5, register-index width.
REQ-003 Parameter FW, 4, funct field width.
REQ-004 Parameter AW, 2, ALUOp width.
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-low reset.
REQ-008 flush  in  1  discard all held entries this cycle (branch mispredict).
REQ-009 in_valid  in  1  ID stage presents an entry.
REQ-010 in_ready  out  1  block accepts an entry; transfer when in_valid & in_ready.
REQ-011 in_pc, in_rs1_data, in_rs2_data, in_imm  in  XLEN each  ID payload.
REQ-012 in_rs1, in_rs2, in_rd  in  RW each  register indices (rs1/rs2 for forwarding).
REQ-013 in_funct  in  FW;  in_aluop  in  AW.
REQ-014 in_ctrl  in  6  {ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg}, bit 5 = ALUSrc.
REQ-015 out_valid  out  1  EX entry valid.
REQ-016 out_ready  in  1  EX accepts; transfer when out_valid & out_ready.
REQ-017 out_* payload  out  widths as in_*  registered copy of accepted entry.
REQ-018 stall_cnt  out  32  cycles with out_valid=1 & out_ready=0.

Function
REQ-019 Two storage entries: main (drives out_*) and skid; states EMPTY (none), FULL (main), SKID (main+skid).
REQ-020 in_ready SHALL be 1 in EMPTY and FULL, 0 in SKID; registered, no combinational path from out_ready.
REQ-021 out_valid SHALL be 1 in FULL and SKID.
REQ-022 EMPTY: in fire -> main<=in, FULL; else stay.
REQ-023 FULL: in fire & out fire -> main<=in, stay FULL; in fire only -> skid<=in, SKID; out fire only -> EMPTY.
REQ-024 SKID: out fire -> main<=skid, FULL; else hold; input ignored.
REQ-025 Latency: accepted entry appears on out_* the cycle after in fire when main is free or draining; throughput one entry per cycle.
REQ-026 Order SHALL be preserved; no entry duplicated or dropped except by flush.
REQ-027 out_ctrl SHALL be 6'b0 whenever out_valid=0 (bubble carries no side effects).
REQ-028 Payload registers SHALL hold value while entry is held (out_ready=0).
REQ-029 flush=1: next state EMPTY, main and skid payload cleared to 0, same-cycle input discarded; an out fire in that cycle counts as completed.
REQ-030 Priority: reset > flush > normal transfer.
REQ-031 stall_cnt SHALL increment by 1 each stalled cycle, saturate at 32'hFFFFFFFF, cleared only by reset.
REQ-032 All widths follow parameters; no truncation of any field.

Reset
REQ-033 reset=0 at clk edge: state EMPTY, all out_* and skid payload 0, out_valid 0, stall_cnt 0.
REQ-034 in_ready SHALL be 0 during reset cycles and 1 the first cycle after reset deasserts.
REQ-035 Reset mid-operation SHALL discard all held entries with no out fire.

Verification
REQ-036 Stream PC 0x0,0x4,0x8 with out_ready=1 -> out_pc 0x0,0x4,0x8 on consecutive cycles, each one cycle after input.
REQ-037 Entry A (pc 0x100) held, out_ready=0, send B (pc 0x104) -> SKID, in_ready=0; out_ready=1 -> A then B, stall_cnt increments per stalled cycle.
REQ-038 SKID state, assert flush with in_valid=1 (pc 0x200) -> next cycle out_valid=0, out_ctrl=0, 0x200 never appears.
REQ-039 reset=0 while FULL with in_ctrl=6'b111111 -> next cycle all outputs 0, stall_cnt 0.
REQ-040 Preload stall_cnt to 32'hFFFFFFFE via long stall -> after 3 more stalled cycles reads 32'hFFFFFFFF.
REQ-041 Random valid/ready/flush, XLEN=32 and XLEN=64 -> scoreboard order, payload bit-exact, no loss outside flush.
